// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register file: NUM_REGS 32-bit read/write registers with
// independent AW/W capture, byte strobes and single-outstanding responses.
// Optional macro AXIL_ADDR_DECODE_ERR_EN: unmapped accesses return SLVERR
// (writes dropped, reads return 0). Without it the word index wraps modulo
// NUM_REGS and every response is OKAY.
module axil_slave_regfile #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS           = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] REG_OUT
);
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_HAVE_ADDR = 2'd1;
    localparam logic [1:0] W_HAVE_DATA = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;
    localparam logic       R_IDLE      = 1'b0;
    localparam logic       R_RESP      = 1'b1;
    localparam logic [1:0] OKAY        = 2'b00;
    localparam logic [1:0] SLVERR      = 2'b10;

    logic [1:0]                          w_state;
    logic                                r_state;
    logic                                live;
    logic [C_S_AXI_ADDR_WIDTH-1:0]       aw_hold;
    logic [C_S_AXI_DATA_WIDTH-1:0]       wd_hold;
    logic [SW-1:0]                       ws_hold;
    logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs;

    logic                                aw_hs, w_hs, ar_hs, commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0]       wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]       wr_data, rd_val;
    logic [SW-1:0]                       wr_strb;
    int unsigned                         wr_idx, rd_idx, wr_word, rd_word;
    logic                                wr_ok, rd_ok;

    // Byte-offset bits and PROT carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

    // READYs are held low for the first cycle out of reset via 'live'.
    assign S_AXI_AWREADY = live && (w_state == W_IDLE || w_state == W_HAVE_DATA);
    assign S_AXI_WREADY  = live && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
    assign S_AXI_ARREADY = live && (r_state == R_IDLE);
    assign REG_OUT       = regs;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = (w_state == W_IDLE && aw_hs && w_hs) ||
                    (w_state == W_HAVE_ADDR && w_hs) ||
                    (w_state == W_HAVE_DATA && aw_hs);

    // Merge held and live halves of the write, then decode both addresses.
    always_comb begin
        wr_addr = (w_state == W_HAVE_ADDR) ? aw_hold : S_AXI_AWADDR;
        wr_data = (w_state == W_HAVE_DATA) ? wd_hold : S_AXI_WDATA;
        wr_strb = (w_state == W_HAVE_DATA) ? ws_hold : S_AXI_WSTRB;
        wr_idx  = 32'(wr_addr[C_S_AXI_ADDR_WIDTH-1:2]);
        rd_idx  = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
`ifdef AXIL_ADDR_DECODE_ERR_EN
        wr_ok   = wr_idx < NUM_REGS;
        rd_ok   = rd_idx < NUM_REGS;
        wr_word = wr_idx;
        rd_word = rd_idx;
`else
        wr_ok   = 1'b1;
        rd_ok   = 1'b1;
        wr_word = wr_idx % NUM_REGS;
        rd_word = rd_idx % NUM_REGS;
`endif
        rd_val = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++)
            if (rd_ok && rd_word == k) rd_val = regs[k];
    end

    // First cycle after reset keeps READYs low.
    always_ff @(posedge ACLK) live <= !ARESET;

    // Write channel FSM: capture AW/W in either order, respond, wait for BREADY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state      <= W_IDLE;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= OKAY;
            aw_hold      <= '0;
            wd_hold      <= '0;
            ws_hold      <= '0;
        end else if (commit) begin
            w_state      <= W_RESP;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_ok ? OKAY : SLVERR;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_hold <= S_AXI_AWADDR;
                        w_state <= W_HAVE_ADDR;
                    end else if (w_hs) begin
                        wd_hold <= S_AXI_WDATA;
                        ws_hold <= S_AXI_WSTRB;
                        w_state <= W_HAVE_DATA;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        w_state      <= W_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register array: byte-lane writes on the commit edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            regs <= '0;
        end else if (commit && wr_ok) begin
            for (int unsigned k = 0; k < NUM_REGS; k++)
                if (wr_word == k)
                    for (int b = 0; b < SW; b++)
                        if (wr_strb[b]) regs[k][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Read channel: sample registers on AR handshake, hold until RREADY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state      <= R_IDLE;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= OKAY;
        end else if (r_state == R_IDLE) begin
            if (ar_hs) begin
                S_AXI_RDATA  <= rd_val;
                S_AXI_RRESP  <= rd_ok ? OKAY : SLVERR;
                S_AXI_RVALID <= 1'b1;
                r_state      <= R_RESP;
            end
        end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            r_state      <= R_IDLE;
        end
    end
endmodule

// File: tb/tb_axil_slave_regfile.sv
// Randomized self-checking bench for axil_slave_regfile against a flat
// register-image model; honours AXIL_ADDR_DECODE_ERR_EN like the design.
module tb_axil_slave_regfile;
    localparam int NR = 4;

    logic              ACLK = 0, ARESET = 1;
    logic [4:0]        AWADDR = 0, ARADDR = 0;
    logic [2:0]        AWPROT = 0, ARPROT = 0;
    logic              AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
    logic [31:0]       WDATA = 0;
    logic [3:0]        WSTRB = 0;
    logic              AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]        BRESP, RRESP;
    logic [31:0]       RDATA;
    logic [32*NR-1:0]  REG_OUT;

    logic [32*NR-1:0]  mdl;
    int checks = 0, errors = 0;

    axil_slave_regfile #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .REG_OUT(REG_OUT)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Address map as seen by software.
    function automatic int unsigned word_of(input logic [4:0] a);
        return 32'(a) >> 2;
    endfunction
    function automatic bit hit(input logic [4:0] a);
`ifdef AXIL_ADDR_DECODE_ERR_EN
        return word_of(a) < NR;
`else
        return 1'b1;
`endif
    endfunction
    function automatic int unsigned slot(input logic [4:0] a);
        return word_of(a) % NR;
    endfunction
    function automatic logic [31:0] exp_rdata(input logic [4:0] a);
        return hit(a) ? mdl[32*slot(a) +: 32] : 32'h0;
    endfunction
    function automatic logic [1:0] exp_resp(input logic [4:0] a);
        return hit(a) ? 2'b00 : 2'b10;
    endfunction

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        logic [32*NR-1:0] nxt;
        logic [1:0]       er;
        bit awd, wd, awh, wh;
        int cyc;
        nxt = mdl;
        if (hit(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) nxt[32*slot(a) + 8*b +: 8] = d[8*b +: 8];
        er = exp_resp(a);
        awd = 0; wd = 0; cyc = 0;
        while (!(awd && wd)) begin
            AWADDR = a; WDATA = d; WSTRB = s;
            AWVALID = !awd && cyc >= aw_dly;
            WVALID  = !wd && cyc >= w_dly;
            awh = AWVALID && AWREADY;
            wh  = WVALID && WREADY;
            tick();
            awd |= awh; wd |= wh; cyc++;
            if (!(awd && wd)) begin
                if (wd)  chk("wready_after_w", WREADY, 0);
                if (awd) chk("awready_after_aw", AWREADY, 0);
                chk("bvalid_early", BVALID, 0);
                chk("reg_early", REG_OUT, mdl);
            end
            if (cyc > 50) begin
                chk("w_timeout", 1, 0);
                awd = 1; wd = 1;
            end
        end
        AWVALID = 0; WVALID = 0;
        chk("bvalid", BVALID, 1);
        chk("reg_out_w", REG_OUT, nxt);
        mdl = nxt;
        for (int i = 0; i < b_dly; i++) begin
            chk("bvalid_hold", BVALID, 1);
            chk("awready_in_resp", AWREADY, 0);
            chk("wready_in_resp", WREADY, 0);
            tick();
        end
        chk("bresp", BRESP, er);
        BREADY = 1;
        tick();
        BREADY = 0;
        chk("bvalid_clr", BVALID, 0);
    endtask

    task automatic do_read(input logic [4:0] a, input int ar_dly, input int r_dly,
                           input logic [31:0] ed, input logic [1:0] er);
        bit done, h;
        int cyc;
        done = 0; cyc = 0;
        while (!done) begin
            ARADDR = a;
            ARVALID = cyc >= ar_dly;
            h = ARVALID && ARREADY;
            tick();
            done = h; cyc++;
            if (!done) chk("rvalid_early", RVALID, 0);
            if (cyc > 50) begin
                chk("r_timeout", 1, 0);
                done = 1;
            end
        end
        ARVALID = 0;
        chk("rvalid", RVALID, 1);
        for (int i = 0; i < r_dly; i++) begin
            chk("rvalid_hold", RVALID, 1);
            chk("arready_in_resp", ARREADY, 0);
            chk("rdata_hold", RDATA, ed);
            tick();
        end
        chk("rdata", RDATA, ed);
        chk("rresp", RRESP, er);
        RREADY = 1;
        tick();
        RREADY = 0;
        chk("rvalid_clr", RVALID, 0);
    endtask

    initial begin
        logic [4:0]  a;
        logic [31:0] old;
        mdl = '0;
        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", AWREADY, 0); chk("rst_wready", WREADY, 0);
        chk("rst_arready", ARREADY, 0); chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);   chk("rst_rdata", RDATA, 0);
        chk("rst_resp", {BRESP, RRESP}, 0); chk("rst_regs", REG_OUT, 0);
        ARESET = 0;
        #1 chk("ready_before_edge", {AWREADY, WREADY, ARREADY}, 0);
        tick();
        chk("ready_after_edge", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Four writes, read back
        for (int i = 0; i < 4; i++) do_write(5'(4*i), 32'(i + 1), 4'hF, 0, 0, 0);
        chk("reg_out_seq", REG_OUT, 128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 4; i++) do_read(5'(4*i), 0, 0, 32'(i + 1), 2'b00);

        // W leads AW by three cycles
        do_write(5'h04, 32'hDEADBEEF, 4'hF, 3, 0, 0);
        chk("reg1_deadbeef", REG_OUT[63:32], 32'hDEADBEEF);
        // AW leads W
        do_write(5'h08, 32'hCAFEF00D, 4'hF, 0, 2, 0);

        // Byte strobes
        do_write(5'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_write(5'h00, 32'h12345678, 4'b0101, 0, 0, 0);
        chk("strobe_0101", REG_OUT[31:0], 32'hFF34FF78);
        do_write(5'h00, 32'h0BADF00D, 4'b0000, 0, 0, 0);
        chk("strobe_none", REG_OUT[31:0], 32'hFF34FF78);

        // Response back-pressure
        do_write(5'h0C, 32'h55AA55AA, 4'hF, 0, 0, 5);
        do_read(5'h0C, 0, 5, 32'h55AA55AA, 2'b00);

        // Unmapped / aliased addresses; unaligned offsets ignored
        do_read(5'h10, 0, 0, exp_rdata(5'h10), exp_resp(5'h10));
        do_write(5'h14, 32'h77777777, 4'hF, 0, 0, 0);
        do_read(5'h17, 0, 0, exp_rdata(5'h17), exp_resp(5'h17));
`ifdef AXIL_ADDR_DECODE_ERR_EN
        chk("unmapped_rd", {RRESP, RDATA}, {2'b10, 32'h0});
`else
        chk("alias_reg1", REG_OUT[63:32], 32'h77777777);
`endif
        do_read(5'h06, 0, 0, mdl[63:32], 2'b00);

        // Read and write to the same register on the same edge: old value
        old = mdl[95:64];
        fork
            do_write(5'h08, 32'h13579BDF, 4'hF, 0, 0, 0);
            do_read(5'h08, 0, 0, old, 2'b00);
        join
        // Read while the write is parked waiting for data: old value
        old = mdl[95:64];
        fork
            do_write(5'h08, 32'h2468ACE0, 4'hF, 0, 3, 1);
            do_read(5'h08, 1, 0, old, 2'b00);
        join
        chk("reg2_after_pending", REG_OUT[95:64], 32'h2468ACE0);

        // Randomized traffic
        for (int n = 0; n < 120; n++) begin
            a = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 2), exp_rdata(a), exp_resp(a));
        end

        // Reset with both responses pending
        AWADDR = 5'h08; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        ARADDR = 5'h00; ARVALID = 1;
        tick();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        chk("pre_rst_bvalid", BVALID, 1);
        chk("pre_rst_rvalid", RVALID, 1);
        ARESET = 1;
        tick();
        ARESET = 0;
        mdl = '0;
        chk("mid_rst_valids", {BVALID, RVALID}, 2'b00);
        chk("mid_rst_regs", REG_OUT, mdl);
        chk("mid_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
        BREADY = 1; RREADY = 1;
        tick();
        chk("post_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        for (int i = 0; i < 3; i++) begin
            chk("no_stale_resp", {BVALID, RVALID}, 2'b00);
            tick();
        end
        BREADY = 0; RREADY = 0;
        do_write(5'h04, 32'h00C0FFEE, 4'hF, 0, 0, 0);
        do_read(5'h04, 0, 0, 32'h00C0FFEE, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
